// File: rtl/sisc_trace_pkg.sv
// rtl/sisc_trace_pkg.sv - shared state encoding, widths and record-width helper for the trace monitor
// Record width depends on SISC_TRACE_TIMESTAMP_EN.
package sisc_trace_pkg;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_DONE  = 2'd2
   } trace_state_e;

   localparam int TS_W = 32;

   function automatic int rec_width(input int pc_w, input int ir_w);
`ifdef SISC_TRACE_TIMESTAMP_EN
      return TS_W + pc_w + ir_w;
`else
      return pc_w + ir_w;
`endif
   endfunction

endpackage

// File: rtl/sisc_trace_fifo.sv
// rtl/sisc_trace_fifo.sv - synchronous trace-record FIFO with full/empty flags
// DEPTH must be a power of two and at least 2; pointers carry one extra wrap bit.
module sisc_trace_fifo #(
   parameter int WIDTH = 48,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_f,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             pop_en;
   logic             push_en;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign pop_en  = pop_i && !empty_o;
   assign push_en = push_i && (!full_o || pop_en);

   // Output is forced to zero when empty so nothing stale is visible after reset.
   assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_en) begin
         wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      end
      if (pop_en) begin
         rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_en) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
      end
   end

endmodule

// File: rtl/sisc_trace_mon.sv
// rtl/sisc_trace_mon.sv - SISC retirement-trace monitor: capture, stream, drop count, halt drain
// Define SISC_TRACE_TIMESTAMP_EN to prefix each record with a 32-bit cycle stamp.
module sisc_trace_mon
   import sisc_trace_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int PC_W   = 16,
   parameter int IR_W   = 32,
   parameter int DROP_W = 8
) (
   input  logic                                clk,
   input  logic                                rst_f,
   input  logic                                ret_valid,
   input  logic [PC_W-1:0]                     ret_pc,
   input  logic [IR_W-1:0]                     ret_ir,
   input  logic                                halt,
   output logic                                tr_valid,
   input  logic                                tr_ready,
   output logic [rec_width(PC_W, IR_W)-1:0]    tr_data,
   output logic [DROP_W-1:0]                   drop_cnt,
   output logic                                done
);

   localparam int REC_W = rec_width(PC_W, IR_W);

   trace_state_e      state_q, state_d;
   logic [DROP_W-1:0] drop_q, drop_d;
   logic              done_q;
   logic              fifo_full;
   logic              fifo_empty;
   logic              pop;
   logic              push_req;
   logic              drop_hit;
   logic [REC_W-1:0]  rec;

`ifdef SISC_TRACE_TIMESTAMP_EN
   logic [TS_W-1:0] ts_q;

   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) begin
         ts_q <= '0;
      end else begin
         ts_q <= ts_q + TS_W'(1);
      end
   end

   assign rec = {ts_q, ret_pc, ret_ir};
`else
   assign rec = {ret_pc, ret_ir};
`endif

   assign pop      = tr_ready && !fifo_empty;
   assign push_req = ret_valid && (state_q == ST_RUN);
   assign drop_hit = push_req && fifo_full && !pop;

   sisc_trace_fifo #(
      .WIDTH (REC_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_f   (rst_f),
      .push_i  (push_req),
      .wdata_i (rec),
      .pop_i   (tr_ready),
      .rdata_o (tr_data),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // The retiring HALT itself is still captured on the cycle halt is seen.
   always_comb begin
      state_d = state_q;
      drop_d  = drop_q;
      case (state_q)
         ST_RUN: begin
            if (drop_hit && (drop_q != '1)) begin
               drop_d = drop_q + DROP_W'(1);
            end
            if (halt) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (fifo_empty) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_DONE;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) begin
         state_q <= ST_RUN;
         drop_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         drop_q  <= drop_d;
         done_q  <= (state_q == ST_DONE);
      end
   end

   assign tr_valid = !fifo_empty;
   assign drop_cnt = drop_q;
   assign done     = done_q;

endmodule

// File: doc/sisc_trace_mon.md
Name: sisc_trace_mon

Overview:
- Retirement-trace monitor for the SISC core: the return path from the processor toward the bench/host.
- Captures one {PC, IR} record per retired instruction into a FIFO and streams it out on a valid/ready interface.
- Counts records dropped when the FIFO is full.
- On halt, drains the remaining records, then flags completion so the bench can end simulation deterministically.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- PC_W, 16, program-counter width.
- IR_W, 32, instruction-register width.
- DROP_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_f  input  1  asynchronous, active-low reset.
- ret_valid  input  1  one instruction retired this cycle.
- ret_pc  input  PC_W  PC of the retired instruction.
- ret_ir  input  IR_W  encoding of the retired instruction.
- halt  input  1  core has executed HALT; level, sampled each cycle.
- tr_valid  output  1  trace record available.
- tr_ready  input  1  consumer accepts the record.
- tr_data  output  PC_W+IR_W (+32 with option)  record, {pc, ir} with PC in the MSBs.
- drop_cnt  output  DROP_W  records lost to a full FIFO; saturating.
- done  output  1  halt seen and FIFO fully drained.

Behaviour:
- Reset (rst_f low, asynchronous): FIFO empty; read/write pointers 0; tr_valid=0; tr_data=0; drop_cnt=0; done=0; state=RUN. Reset asserted mid-stream discards all queued records.
- FIFO:
  - Registered storage with read and write pointers of log2(DEPTH)+1 bits; the extra MSB distinguishes full from empty.
  - Pointers wrap modulo DEPTH.
  - tr_data is driven from the entry at the read pointer, so tr_valid = !empty.
  - Write-to-visible latency: a record written on edge N shows tr_valid=1 after edge N.
- Push: ret_valid=1 and state=RUN.
  - Not full: write the record.
  - Full: no write; drop_cnt increments, saturating at all-ones.
- Push while full with a simultaneous pop (tr_valid & tr_ready): the push succeeds, no drop. Full status for the push decision is evaluated after accounting for the same-cycle pop.
- Pop: tr_valid & tr_ready advances the read pointer.
- tr_valid must not drop, and tr_data must not change, while tr_valid=1 and tr_ready=0.
- FSM:
  - RUN: accept pushes. halt=1 moves to DRAIN next edge. A ret_valid on the same cycle as halt is still accepted, because the HALT instruction itself retires.
  - DRAIN: pushes ignored; ret_valid is not counted as a drop. Leaves to DONE on the first edge where the FIFO is empty (including on entry if already empty).
  - DONE: done=1 (registered; asserted the cycle after DONE is entered). Stays in DONE until reset; halt deassertion is ignored.
- drop_cnt holds its value in DRAIN and DONE.

Optional Feature:
- Macro: SISC_TRACE_TIMESTAMP_EN.
- Defined:
  - A 32-bit free-running cycle counter, reset to 0, increments every clk and wraps at 2^32.
  - Each record is {cycle, pc, ir}, with cycle in the MSBs and the counter value sampled on the push cycle.
  - tr_data width becomes 32+PC_W+IR_W.
- Undefined: no counter; tr_data width is PC_W+IR_W.
- Everything else is identical.

Decomposition:
- Shared package sisc_trace_pkg holds:
  - state encoding constants ST_RUN=2'd0, ST_DRAIN=2'd1, ST_DONE=2'd2;
  - the localparam for timestamp width, TS_W=32;
  - a function giving record width from PC_W/IR_W and the macro.
- One natural sub-module, sisc_trace_fifo: synchronous FIFO with push/pop/full/empty, parameterized by width and depth.
- The top level holds the FSM, drop counter and optional timestamp.

Test Plan:
- Reset/idle: hold rst_f=0 for 20 ns, release -> tr_valid=0, drop_cnt=0, done=0. Assert rst_f low mid-stream with 3 records queued -> tr_valid=0 immediately, before the next edge.
- Basic stream, tr_ready=1: ret_valid with pc=0x0000 ir=0x88000001, then pc=0x0001 ir=0x21100000 -> tr_data=0x000088000001 the cycle after the first push, then 0x000121100000, in order.
- Overflow, DEPTH=8, tr_ready=0: push 11 records -> the first 8 are retained and drop_cnt=3. Raise tr_ready -> exactly records 0..7 emerge in order. Push 300 more while tr_ready=0 -> drop_cnt saturates at 255.
- Full with simultaneous pop: FIFO full, tr_ready=1 and ret_valid=1 on the same cycle -> no drop, count stays 8, the new record appears last.
- Backpressure stability: tr_valid=1 and tr_ready toggled 0,0,1 -> tr_data constant until the accepting edge.
- Halt drain: 4 records queued, halt=1 together with ret_valid (pc=0x0005) -> 5 records emerge; ret_valid pulses during DRAIN are neither stored nor counted; done=1 the cycle after the FIFO empties and stays 1 after halt falls. With SISC_TRACE_TIMESTAMP_EN, timestamps of consecutive pushes are strictly increasing and equal to the push cycle index.
